// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the read- and write-side controllers of the clock-crossing FIFO.
// Conversions work on a wide zero-extended vector so any COUNTER_WIDTH up to PtrMaxW is handled.
package fifo_ptr_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT     = 3;
  localparam int unsigned MAX_COUNTER_VALUE_DEFAULT = 5;
  localparam int unsigned PtrMaxW                   = 16;

  typedef logic [PtrMaxW-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits decode to zero, so the narrow result is exact after truncation.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Brings the writer's gray pointer into the read clock domain and decodes it to binary,
// accepting a value only once it has been seen stable and inside the pointer range.
module gray_ptr_sync
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter int unsigned MAX_COUNTER_VALUE = MAX_COUNTER_VALUE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] wr_gray_in,
  output logic [COUNTER_WIDTH-1:0] wr_bin
);

  logic [COUNTER_WIDTH-1:0] sync1_q, sync2_q, sync3_q;
  logic [COUNTER_WIDTH-1:0] wr_bin_q, wr_bin_d;
  ptr_wide_t                sync2_bin;

  always_comb begin
    sync2_bin = gray2bin(ptr_wide_t'(sync2_q));
    wr_bin_d  = wr_bin_q;
    // The MAX-1 -> 0 wrap may flip several gray bits; wait for two equal samples.
    if ((sync2_q == sync3_q) && (sync2_bin < ptr_wide_t'(MAX_COUNTER_VALUE))) begin
      wr_bin_d = COUNTER_WIDTH'(sync2_bin);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      wr_bin_q <= '0;
    end else begin
      sync1_q  <= wr_gray_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      wr_bin_q <= wr_bin_d;
    end
  end

  assign wr_bin = wr_bin_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer controller of the clock-crossing FIFO: empty/level, RAM read strobe,
// valid/ready output stage and the gray read pointer returned to the write domain.
module async_fifo_rd_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter int unsigned MAX_COUNTER_VALUE = MAX_COUNTER_VALUE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] wr_gray_in,
  output logic [COUNTER_WIDTH-1:0] rd_gray_out,
  output logic [COUNTER_WIDTH-1:0] ram_rd_addr,
  output logic                     ram_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     empty,
  output logic [COUNTER_WIDTH-1:0] level
);

  localparam logic [COUNTER_WIDTH-1:0] LastPtr = COUNTER_WIDTH'(MAX_COUNTER_VALUE - 1);
  localparam logic [COUNTER_WIDTH-1:0] MaxMod  = COUNTER_WIDTH'(MAX_COUNTER_VALUE);

  logic [COUNTER_WIDTH-1:0] wr_bin;
  logic [COUNTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNTER_WIDTH-1:0] rd_gray_q, rd_gray_d;
  logic                     out_valid_q, out_valid_d;

  gray_ptr_sync #(
    .COUNTER_WIDTH    (COUNTER_WIDTH),
    .MAX_COUNTER_VALUE(MAX_COUNTER_VALUE)
  ) u_wr_ptr_sync (
    .clock     (clock),
    .reset     (reset),
    .wr_gray_in(wr_gray_in),
    .wr_bin    (wr_bin)
  );

  always_comb begin
    empty = (rd_ptr_q == wr_bin);
    // Modular wrap folded into W bits; the true result is always below MAX.
    if (wr_bin >= rd_ptr_q) begin
      level = wr_bin - rd_ptr_q;
    end else begin
      level = wr_bin + MaxMod - rd_ptr_q;
    end
    ram_rd_en = !empty && (out_ready || !out_valid_q);
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_gray_d   = rd_gray_q;
    out_valid_d = out_valid_q;
    if (ram_rd_en) begin
      rd_ptr_d    = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + COUNTER_WIDTH'(1);
      rd_gray_d   = COUNTER_WIDTH'(bin2gray(ptr_wide_t'(rd_ptr_d)));
      out_valid_d = 1'b1;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_gray_q   <= rd_gray_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_gray_out = rd_gray_q;
  assign ram_rd_addr = rd_ptr_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomised bench for async_fifo_rd_ctrl: a writer model feeds gray pointers (with glitches and
// invalid codes) and a slot-order scoreboard predicts reads, empty, level and the output stage.
module tb_async_fifo_rd_ctrl;

  localparam int W   = 3;
  localparam int MAX = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] wr_gray_in;
  logic [W-1:0] rd_gray_out;
  logic [W-1:0] ram_rd_addr;
  logic         ram_rd_en;
  logic         out_valid;
  logic         out_ready;
  logic         empty;
  logic [W-1:0] level;

  async_fifo_rd_ctrl #(
    .COUNTER_WIDTH    (W),
    .MAX_COUNTER_VALUE(MAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_gray_in (wr_gray_in),
    .rd_gray_out(rd_gray_out),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_en  (ram_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .empty      (empty),
    .level      (level)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int to_bin(input int g);
    int b = 0;
    for (int i = W - 1; i >= 0; i--) begin
      b |= (((g >> i) & 1) ^ ((b >> (i + 1)) & 1)) << i;
    end
    return b;
  endfunction

  // Reference state: writer pointer, the reader's view of it, and words in flight by slot.
  int wr_ptr, wr_seen, rd_pos, outstanding, invalid_left, ready_pct;
  bit valid_m, last_glitch;
  int samples[$];
  int slots[$];

  task automatic model_reset();
    wr_ptr       = 0;
    wr_seen      = 0;
    rd_pos       = 0;
    outstanding  = 0;
    invalid_left = 0;
    valid_m      = 1'b0;
    last_glitch  = 1'b0;
    samples      = '{0, 0, 0};
    slots.delete();
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      int  drive, r, lvl_m, g2, g3;
      bit  empty_m, en_m, rdy;
      @(negedge clock);
      if (invalid_left > 0) begin
        drive = 5;  // gray 101 decodes to 6, outside the slot range
        invalid_left--;
        last_glitch = 1'b0;
      end else begin
        if (outstanding < MAX - 1 && $urandom_range(0, 2) == 0) begin
          slots.push_back(wr_ptr);
          wr_ptr = (wr_ptr + 1) % MAX;
          outstanding++;
        end
        drive = to_gray(wr_ptr);
        r = int'($urandom_range(0, 31));
        if (r == 0 && !last_glitch) begin
          drive = int'($urandom_range(0, 7));
          last_glitch = 1'b1;
        end else begin
          last_glitch = 1'b0;
          if (r == 1) invalid_left = 3;
        end
      end
      rdy        = ($urandom_range(0, 99) < ready_pct);
      wr_gray_in = W'(drive);
      out_ready  = rdy;
      #1;
      empty_m = (rd_pos == wr_seen);
      lvl_m   = (wr_seen + MAX - rd_pos) % MAX;
      en_m    = !empty_m && (rdy || !valid_m);
      check_eq("empty", empty, empty_m);
      check_eq("level", level, lvl_m);
      check_eq("ram_rd_en", ram_rd_en, en_m);
      check_eq("out_valid", out_valid, valid_m);
      check_eq("rd_gray_out", rd_gray_out, to_gray(rd_pos));
      if (en_m) begin
        if (slots.size() == 0) check_eq("read_without_write", 1, 0);
        else check_eq("ram_rd_addr", ram_rd_addr, slots[0]);
      end
      @(posedge clock);
      // Reader adopts a pointer only after two equal samples of an in-range code.
      g2 = samples[samples.size() - 2];
      g3 = samples[samples.size() - 3];
      if (g2 == g3 && to_bin(g2) < MAX) wr_seen = to_bin(g2);
      samples.push_back(drive);
      void'(samples.pop_front());
      if (en_m) begin
        rd_pos = (rd_pos + 1) % MAX;
        if (slots.size() > 0) void'(slots.pop_front());
        outstanding--;
        valid_m = 1'b1;
      end else if (rdy && valid_m) begin
        valid_m = 1'b0;
      end
    end
  endtask

  task automatic check_reset_values(input string phase);
    check_eq({phase, "_empty"}, empty, 1);
    check_eq({phase, "_level"}, level, 0);
    check_eq({phase, "_out_valid"}, out_valid, 0);
    check_eq({phase, "_rd_gray_out"}, rd_gray_out, 0);
    check_eq({phase, "_ram_rd_en"}, ram_rd_en, 0);
    check_eq({phase, "_ram_rd_addr"}, ram_rd_addr, 0);
  endtask

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b1;
    wr_gray_in = '0;
    ready_pct  = 75;
    model_reset();
    #3;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;

    run_cycles(800);
    ready_pct = 10;   // mostly stalled: FIFO fills, output held
    run_cycles(300);
    ready_pct = 95;   // drain with back-to-back reads
    run_cycles(300);
    ready_pct = 60;
    run_cycles(400);

    // Asynchronous reset while a word is being presented.
    for (int k = 0; k < 50 && !valid_m; k++) run_cycles(1);
    check_eq("pre_reset_valid", out_valid, 1);
    @(negedge clock);
    #2;
    reset      = 1'b1;
    wr_gray_in = '0;
    #1;
    check_reset_values("mid_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    ready_pct = 70;
    run_cycles(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
